// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_t : FSM state encoding (IDLE, ACCESS, WAIT, RESP)
//   F3_*        : RV32I load/store funct3 encodings
//   is_legal    : funct3 legality for a load or a store
//   is_aligned  : natural alignment check for the access size in funct3
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned variants exist only for loads.
   function automatic logic is_legal(input logic write, input logic [2:0] funct3);
      logic ok;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~write;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // funct3[1:0] carries the access size: 00 byte, 01 half, 10 word.
   function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] off);
      logic ok;
      case (funct3[1:0])
         2'b01:   ok = ~off[0];
         2'b10:   ok = (off == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between control_unit and the load/store unit.
//   req_valid/req_ready       : request handshake
//   req_write/funct3/addr/wdata: request payload
//   resp_valid/rdata/error    : single-cycle completion pulse and result
// Modports: master = control_unit side, slave = load_store_unit side.
interface lsu_if #(
   parameter int ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_error;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling for the load/store unit.
//   funct3_i, off_i : access type and byte offset within the word
//   st_data_i       : raw store data; st_data_o/st_mask_o are lane-replicated data and byte enables
//   ld_data_i       : raw RAM word; ld_data_o is the shifted, extended load result
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] st_data_o,
   output logic [3:0]  st_mask_o,
   input  logic [31:0] ld_data_i,
   output logic [31:0] ld_data_o
);

   logic [31:0] shifted_s;

   // Store lane replication and byte-enable generation.
   always_comb begin
      st_data_o = 32'd0;
      st_mask_o = 4'b0000;
      case (funct3_i[1:0])
         2'b00: begin
            st_data_o = {4{st_data_i[7:0]}};
            st_mask_o = 4'b0001 << off_i;
         end
         2'b01: begin
            st_data_o = {2{st_data_i[15:0]}};
            st_mask_o = 4'b0011 << off_i;
         end
         2'b10: begin
            st_data_o = st_data_i;
            st_mask_o = 4'b1111;
         end
         default: begin
            st_data_o = 32'd0;
            st_mask_o = 4'b0000;
         end
      endcase
   end

   // Load extraction: move the addressed byte/half to bit 0, then extend.
   always_comb begin
      shifted_s = ld_data_i >> {off_i, 3'b000};
      ld_data_o = 32'd0;
      case (funct3_i)
         F3_B:    ld_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
         F3_H:    ld_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
         F3_W:    ld_data_o = shifted_s;
         F3_BU:   ld_data_o = {24'd0, shifted_s[7:0]};
         F3_HU:   ld_data_o = {16'd0, shifted_s[15:0]};
         default: ld_data_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store, checks legality/alignment,
// drives a single-port synchronous RAM with one-cycle read latency and
// returns a one-cycle response pulse.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request/response handshake with control_unit
//   mem_addr_o      : word-aligned RAM address
//   mem_wdata_o     : lane-replicated store data
//   mem_wmask_o     : byte write enables
//   mem_we_o/re_o   : registered write/read strobes
//   mem_rdata_i     : RAM read data, valid one cycle after mem_re_o
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_if.slave              bus,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_wmask_o,
   output logic              mem_we_o,
   output logic              mem_re_o,
   input  logic [31:0]       mem_rdata_i
);

   lsu_state_t        state_q;
   logic              write_q;
   logic [2:0]        funct3_q;
   logic [1:0]        off_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic [3:0]        mem_wmask_q;
   logic              mem_we_q;
   logic              mem_re_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_error_q;

   logic [2:0]  a_funct3_s;
   logic [1:0]  a_off_s;
   logic [31:0] st_data_s;
   logic [3:0]  st_mask_s;
   logic [31:0] ld_data_s;
   logic        ok_s;

   // The single aligner serves the incoming request while idle (store
   // formatting at accept) and the captured request afterwards (load extraction).
   assign a_funct3_s = (state_q == IDLE) ? bus.req_funct3     : funct3_q;
   assign a_off_s    = (state_q == IDLE) ? bus.req_addr[1:0]  : off_q;
   assign ok_s       = is_legal(bus.req_write, bus.req_funct3)
                     & is_aligned(bus.req_funct3, bus.req_addr[1:0]);

   lsu_align u_align (
      .funct3_i  (a_funct3_s),
      .off_i     (a_off_s),
      .st_data_i (bus.req_wdata),
      .st_data_o (st_data_s),
      .st_mask_o (st_mask_s),
      .ld_data_i (mem_rdata_i),
      .ld_data_o (ld_data_s)
   );

   // Transaction FSM with registered strobes and response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         mem_wmask_q  <= 4'd0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  write_q  <= bus.req_write;
                  funct3_q <= bus.req_funct3;
                  off_q    <= bus.req_addr[1:0];
                  if (ok_s) begin
                     mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                     if (bus.req_write) begin
                        mem_wdata_q <= st_data_s;
                        mem_wmask_q <= st_mask_s;
                        mem_we_q    <= 1'b1;
                     end else begin
                        mem_wdata_q <= 32'd0;
                        mem_wmask_q <= 4'd0;
                        mem_re_q    <= 1'b1;
                     end
                     state_q <= ACCESS;
                  end else begin
                     // Bad requests skip memory entirely.
                     resp_valid_q <= 1'b1;
                     resp_error_q <= 1'b1;
                     resp_rdata_q <= 32'd0;
                     state_q      <= RESP;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               mem_we_q <= 1'b0;
               mem_re_q <= 1'b0;
               if (write_q) begin
                  resp_valid_q <= 1'b1;
                  resp_error_q <= 1'b0;
                  resp_rdata_q <= 32'd0;
                  state_q      <= RESP;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               resp_valid_q <= 1'b1;
               resp_error_q <= 1'b0;
               resp_rdata_q <= ld_data_s;
               state_q      <= RESP;
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               state_q      <= IDLE;
            end
            default: begin
               mem_we_q     <= 1'b0;
               mem_re_q     <= 1'b0;
               resp_valid_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE) && rst_n;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_error = resp_error_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign mem_wmask_o    = mem_wmask_q;
   assign mem_we_o       = mem_we_q;
   assign mem_re_o       = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic [31:0] ram_word;

   int checks;
   int failures;
   int re_cnt;
   int we_cnt;
   int both_cnt;

   lsu_if #(.ADDR_W(32)) bus ();

   load_store_unit #(.ADDR_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_wmask_o (mem_wmask),
      .mem_we_o    (mem_we),
      .mem_re_o    (mem_re),
      .mem_rdata_i (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: one-cycle read latency returning the word set by the stimulus.
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= ram_word;
   end

   // Strobe counters used to prove bad requests never reach memory.
   always @(posedge clk) begin
      if (mem_re) re_cnt <= re_cnt + 1;
      if (mem_we) we_cnt <= we_cnt + 1;
      if (mem_re && mem_we) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a request for one accept edge; returns in cycle 1.
   task automatic drive_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data);
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = data;
      bus.req_valid  = 1'b1;
      step();
      bus.req_valid  = 1'b0;
   endtask

   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
      ram_word = word;
      check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
      drive_req(1'b0, f3, addr, 32'd0);
      check({tag, "_re_c1"}, {31'd0, mem_re}, 32'd1);
      check({tag, "_we_c1"}, {31'd0, mem_we}, 32'd0);
      check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
      step();
      check({tag, "_re_c2"}, {31'd0, mem_re}, 32'd0);
      check({tag, "_rv_c2"}, {31'd0, bus.resp_valid}, 32'd0);
      step();
      check({tag, "_rv_c3"}, {31'd0, bus.resp_valid}, 32'd1);
      check({tag, "_rdata"}, bus.resp_rdata, exp);
      check({tag, "_err"}, {31'd0, bus.resp_error}, 32'd0);
      step();
      check({tag, "_rv_c4"}, {31'd0, bus.resp_valid}, 32'd0);
      check({tag, "_hold"}, bus.resp_rdata, exp);
   endtask

   task automatic run_err(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] addr);
      int re0;
      int we0;
      re0 = re_cnt;
      we0 = we_cnt;
      drive_req(w, f3, addr, 32'h1234_5678);
      check({tag, "_rv_c1"}, {31'd0, bus.resp_valid}, 32'd1);
      check({tag, "_err"}, {31'd0, bus.resp_error}, 32'd1);
      check({tag, "_rdata"}, bus.resp_rdata, 32'd0);
      check({tag, "_strobe"}, {30'd0, mem_re, mem_we}, 32'd0);
      step();
      check({tag, "_rv_c2"}, {31'd0, bus.resp_valid}, 32'd0);
      check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
      step();
      check({tag, "_re_cnt"}, re_cnt, re0);
      check({tag, "_we_cnt"}, we_cnt, we0);
   endtask

   initial begin
      checks = 0; failures = 0;
      re_cnt = 0; we_cnt = 0; both_cnt = 0;
      mem_rdata = 32'd0; ram_word = 32'd0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      rst_n = 1'b0;
      repeat (3) step();

      // Reset state
      check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      check("rst_rv", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_wmask", {28'd0, mem_wmask}, 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_ready", {31'd0, bus.req_ready}, 32'd1);

      // Loads
      run_load("lw100", F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      run_load("lb103", F3_B, 32'h0000_0103, 32'h80FF_0011, 32'hFFFF_FF80);
      run_load("lbu103", F3_BU, 32'h0000_0103, 32'h80FF_0011, 32'h0000_0080);
      run_load("lh102", F3_H, 32'h0000_0102, 32'h80FF_0011, 32'hFFFF_80FF);
      run_load("lhu102", F3_HU, 32'h0000_0102, 32'h80FF_0011, 32'h0000_80FF);

      // SB at 0x202
      drive_req(1'b1, F3_B, 32'h0000_0202, 32'h1234_5678);
      check("sb_we_c1", {31'd0, mem_we}, 32'd1);
      check("sb_re_c1", {31'd0, mem_re}, 32'd0);
      check("sb_wmask", {28'd0, mem_wmask}, 32'h0000_0004);
      check("sb_wdata", mem_wdata, 32'h7878_7878);
      check("sb_addr", mem_addr, 32'h0000_0200);
      check("sb_rv_c1", {31'd0, bus.resp_valid}, 32'd0);
      step();
      check("sb_rv_c2", {31'd0, bus.resp_valid}, 32'd1);
      check("sb_rdata", bus.resp_rdata, 32'd0);
      check("sb_err", {31'd0, bus.resp_error}, 32'd0);
      check("sb_we_c2", {31'd0, mem_we}, 32'd0);
      step();
      check("sb_rv_c3", {31'd0, bus.resp_valid}, 32'd0);

      // Misaligned and illegal requests
      run_err("lh101", 1'b0, F3_H, 32'h0000_0101);
      run_err("sw102", 1'b1, F3_W, 32'h0000_0102);
      run_err("ld011", 1'b0, 3'b011, 32'h0000_0000);
      run_err("st100", 1'b1, 3'b100, 32'h0000_0000);

      // Reset during WAIT of an LW
      ram_word = 32'hDEAD_BEEF;
      drive_req(1'b0, F3_W, 32'h0000_0100, 32'd0);
      step();
      rst_n = 1'b0;
      #1;
      check("abort_rv", {31'd0, bus.resp_valid}, 32'd0);
      check("abort_err", {31'd0, bus.resp_error}, 32'd0);
      check("abort_rdata", bus.resp_rdata, 32'd0);
      check("abort_strobes", {30'd0, mem_re, mem_we}, 32'd0);
      check("abort_addr", mem_addr, 32'd0);
      check("abort_wmask", {28'd0, mem_wmask}, 32'd0);
      check("abort_ready", {31'd0, bus.req_ready}, 32'd0);
      step();
      step();
      check("abort_rv_held", {31'd0, bus.resp_valid}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("abort_rel_ready", {31'd0, bus.req_ready}, 32'd1);

      // SH at 0x0 after reset
      drive_req(1'b1, F3_H, 32'h0000_0000, 32'hAAAA_5555);
      check("sh_we", {31'd0, mem_we}, 32'd1);
      check("sh_wmask", {28'd0, mem_wmask}, 32'h0000_0003);
      check("sh_wdata", mem_wdata, 32'h5555_5555);
      check("sh_addr", mem_addr, 32'd0);
      step();
      check("sh_rv_c2", {31'd0, bus.resp_valid}, 32'd1);
      check("sh_err", {31'd0, bus.resp_error}, 32'd0);
      step();
      check("sh_rv_c3", {31'd0, bus.resp_valid}, 32'd0);

      check("re_we_overlap", both_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the multicycle core. It sits between `control_unit` and the unified single-port synchronous RAM. It accepts one load or store request per transaction. For each request it:
- checks alignment and `funct3` legality,
- generates a word-aligned address, byte mask and lane-replicated write data,
- sequences the RAM's one-cycle read latency,
- returns a sign- or zero-extended load value with a single-cycle response pulse.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request offered by `control_unit`.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I load/store `funct3`.
- `req_addr` in `ADDR_W`: byte address (rs1 + imm).
- `req_wdata` in 32: store data (rs2).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result. 0 for stores and errors.
- `resp_error` out 1: misaligned access or illegal `funct3`. Valid with `resp_valid`.
- `mem_addr` out `ADDR_W`: word address, `{req_addr[ADDR_W-1:2], 2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wmask` out 4: byte write enables.
- `mem_we` out 1: write strobe.
- `mem_re` out 1: read strobe.
- `mem_rdata` in 32: RAM read data, valid exactly one cycle after `mem_re`.

## Operation
States: IDLE, ACCESS, WAIT, RESP.

- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: capture `write`, `funct3`, `addr`, `wdata`.
  - If the request is illegal or misaligned → RESP with `error` = 1.
  - Otherwise → ACCESS.
- **ACCESS**
  - Drive `mem_re` (load) or `mem_we` + `mem_wmask` (store) for exactly one cycle.
  - Load → WAIT. Store → RESP.
- **WAIT**
  - Sample `mem_rdata` and format it into the response register → RESP.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle → IDLE.

Legality:
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- All other encodings set `error`.

Alignment:
- Halfword requires `addr[0]` = 0.
- Word requires `addr[1:0]` = 0.
- Misaligned requests never touch memory.

Store formatting (`off` = `addr[1:0]`):
- SB: `wdata` = `{4{wdata[7:0]}}`, `wmask` = 4'b0001 << `off`.
- SH: `wdata` = `{2{wdata[15:0]}}`, `wmask` = 4'b0011 << `off`.
- SW: `wmask` = 4'b1111.

Load formatting:
- `shifted` = `mem_rdata >> (8*off)`.
- LB/LH sign-extend bit 7/15 of `shifted`.
- LBU/LHU zero-extend.
- LW passes `shifted` through.

Control and memory strobes:
- `resp_valid`, `mem_re` and `mem_we` are registered outputs. They are never combinational from `req_*`.
- `mem_re` and `mem_we` are never high together.

## Timing
Cycle numbering: accept edge = cycle 0.
- Load: `mem_re` high in cycle 1, `resp_valid` in cycle 3.
- Store: `mem_we` high in cycle 1, `resp_valid` in cycle 2.
- Error: `resp_valid` + `resp_error` in cycle 1. No memory strobe.

Handshake and holding:
- `req_ready` = (state == IDLE) && `rst_n`.
- Requests are ignored outside IDLE.
- No back-pressure on the response: `control_unit` must be waiting when `resp_valid` fires.
- `req_valid` high in the same cycle RESP returns to IDLE is not accepted until IDLE is visible, so throughput is one request per 2–4 cycles.
- `mem_addr`, `mem_wdata` and `mem_wmask` hold their captured values from ACCESS until the next accept. They are 0 after reset.
- `resp_rdata` and `resp_error` hold until the next response.

Reset:
- `rst_n` low at any time forces IDLE immediately.
- All outputs clear: `resp_*` = 0, `mem_*` = 0, `req_ready` = 0 while held.
- An in-flight access is aborted with no response. A store aborted in ACCESS has its `mem_we` cleared asynchronously.
- After release, `req_ready` = 1 on the first cycle.

## Structure
- `lsu_pkg`:
  - `lsu_state_t` enum (IDLE, ACCESS, WAIT, RESP).
  - `funct3` localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - `function is_legal(write, funct3)`.
- Sub-module `lsu_align`: purely combinational store lane/mask generation and load extraction/extension. It is instantiated once. The FSM and registers live in `load_store_unit`.

## Test plan
- LW at 0x100 with RAM word 0xDEADBEEF → `mem_re` in cycle 1 with `mem_addr` 0x100. `resp_rdata` 0xDEADBEEF and `resp_valid` in cycle 3.
- LB at 0x103 then LBU at 0x103 with word 0x80FF_0011 → `resp_rdata` 0xFFFFFF80, then 0x00000080.
- SB data 0x12345678 at 0x202 → `mem_we` in cycle 1, `mem_wmask` 0100, `mem_wdata` 0x78787878. `resp_valid` in cycle 2 with `resp_rdata` 0.
- LH at 0x101, and SW at 0x102 → `resp_error` = 1 in cycle 1, no `mem_re`/`mem_we` ever.
- Illegal `funct3` 011 load and 100 store → `resp_error` = 1, no memory strobe.
- Assert `rst_n` low during WAIT of an LW → no `resp_valid`, all outputs 0. After release `req_ready` = 1, and a new SH at 0x0 (data 0xAAAA_5555) gives `mem_wmask` 0011 and `mem_wdata` 0x55555555.
